// File: rtl/afu_fifo_pkg.sv
// ---------------------------------------------------------------------------
// afu_fifo_pkg
// Shared constants and types for the AFU MMIO word FIFO:
//   FIFO_DATA_W / FIFO_DEPTH / FIFO_CNT_W : default geometry
//   FIFO_DATA_ADDR / FIFO_STAT_ADDR       : MMIO offsets of data and status
//   t_fifo_status                         : layout of the host status read
//   pack_status()                         : builds a t_fifo_status word
// ---------------------------------------------------------------------------
package afu_fifo_pkg;

  localparam int FIFO_DATA_W = 64;
  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [15:0] FIFO_DATA_ADDR = 16'h0020;
  localparam logic [15:0] FIFO_STAT_ADDR = 16'h0022;

  typedef struct packed {
    logic [FIFO_CNT_W-1:0] count;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;
  } t_fifo_status;

  function automatic t_fifo_status pack_status(
    input logic [FIFO_CNT_W-1:0] cnt,
    input logic                  ful,
    input logic                  emp,
    input logic                  ovf,
    input logic                  unf
  );
    t_fifo_status s;
    s.count     = cnt;
    s.full      = ful;
    s.empty     = emp;
    s.overflow  = ovf;
    s.underflow = unf;
    return s;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
// DEPTH x DATA_W storage for the word FIFO. Contents are not reset.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address (asynchronous read)
//   rdata_o  : word at raddr_i
// ---------------------------------------------------------------------------
module fifo_ram
  import afu_fifo_pkg::*;
#(
  parameter  int DATA_W = FIFO_DATA_W,
  parameter  int DEPTH  = FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Single write port; storage deliberately has no reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mmio_word_fifo.sv
// ---------------------------------------------------------------------------
// mmio_word_fifo
// First-word-fall-through circular FIFO between the AFU MMIO write decode
// (push) and MMIO read mux (pop), with host-visible occupancy and sticky
// error flags.
//   clk, rst_n         : clock, asynchronous active-low reset
//   wr_en, wr_data     : push request and word
//   rd_en              : pop request
//   rd_data            : head word, 0 when empty
//   empty, full, count : occupancy status (registered)
//   overflow           : sticky, push while full without a pop
//   underflow          : sticky, pop while empty
//   clr_err            : synchronous clear of the sticky flags
// ---------------------------------------------------------------------------
module mmio_word_fifo
  import afu_fifo_pkg::*;
#(
  parameter  int DATA_W = FIFO_DATA_W,
  parameter  int DEPTH  = FIFO_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_s, pop_s;
  logic [DATA_W-1:0] ram_rdata_s;

  // Accept/reject decisions, next pointers, count and sticky flags.
  always_comb begin
    // A full FIFO still takes a push when a pop frees the head slot in the
    // same cycle; an empty FIFO never lets the pop see the incoming word.
    push_s   = wr_en && (!full_q || rd_en);
    pop_s    = rd_en && !empty_q;
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A new error outranks a concurrent clear.
    ovf_d = (ovf_q && !clr_err) || (wr_en && full_q && !rd_en);
    unf_d = (unf_q && !clr_err) || (rd_en && empty_q);
  end

  // Pointer, count and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == CNT_W'(0));
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata_s)
  );

  // Masking on empty_q hides stale storage, including right after reset.
  assign rd_data   = empty_q ? '0 : ram_rdata_s;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
